// File: rtl/agc_mem_sequencer.sv
// AGC memory-cycle sequencer: read, capture into G, restore/write, respond.
// Optional AGC_EDIT_EN enables editing transforms on writes to 12'h010-12'h013.
module agc_mem_sequencer #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 15,
  parameter logic [AW-1:0] ERASABLE_TOP = 12'h3FF
) (
  input  logic          tp,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_fault,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_fixed;
  logic          r_fault;
  logic [DW-1:0] r_g;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_accept;
  logic [DW-1:0] w_edit;

  // DONE overlaps with IDLE so back-to-back requests run every 4 cycles
  assign req_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept  = req_valid && req_ready;

`ifdef AGC_EDIT_EN
  always_comb begin
    w_edit = r_wdata;
    unique case (r_addr)
      12'h010: w_edit = {r_wdata[0], r_wdata[DW-1:1]};
      12'h011: w_edit = {r_wdata[DW-1], r_wdata[DW-1:1]};
      12'h012: w_edit = {r_wdata[DW-2:0], r_wdata[DW-1]};
      12'h013: w_edit = r_wdata >> 7;
      default: w_edit = r_wdata;
    endcase
  end
`else
  assign w_edit = r_wdata;
`endif

  always_ff @(posedge tp or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fixed     <= 1'b0;
      r_fault     <= 1'b0;
      r_g         <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_fixed    <= (req_addr > ERASABLE_TOP);
            r_fault    <= 1'b0;
            r_mem_addr <= req_addr;
            r_state    <= S_READ;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // restore path writes back the word just read
          r_g         <= mem_rdata;
          r_mem_wdata <= r_we ? w_edit : mem_rdata;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_fault <= r_fixed & r_we;
          r_rdata <= r_g;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (r_state == S_WRITE) && !r_fixed;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_fault = (r_state == S_DONE) && r_fault;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_agc_mem_sequencer.sv
// Directed bench for agc_mem_sequencer with a behavioural memory model.
// Edit-address expectations follow AGC_EDIT_EN.
module tb_agc_mem_sequencer;

  logic        tp = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [14:0] req_wdata = '0;
  logic        rsp_valid;
  logic [14:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [14:0] mem_wdata;
  logic [14:0] mem_rdata;

  logic [14:0] mem [0:4095] = '{default: 15'h0};
  logic        pl_en = 1'b0;
  logic [11:0] pl_a = '0;
  logic [14:0] pl_d = '0;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;

`ifdef AGC_EDIT_EN
  localparam logic [14:0] E010 = 15'h4000;
  localparam logic [14:0] E013 = 15'h0081;
`else
  localparam logic [14:0] E010 = 15'h0001;
  localparam logic [14:0] E013 = 15'h4080;
`endif

  agc_mem_sequencer dut (
    .tp(tp), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 tp = ~tp;

  assign mem_rdata = mem[mem_addr];

  always @(posedge tp) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [14:0] d);
    @(negedge tp);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge tp);
    pl_en = 1'b0;
  endtask

  task automatic xact(input  logic        we,
                      input  logic [11:0] a,
                      input  logic [14:0] d,
                      output logic [14:0] rd,
                      output logic        flt,
                      output int          ens,
                      output logic [14:0] wseen,
                      output int          lat);
    int n;
    rd = '0; flt = 1'b0; ens = 0; wseen = '0; lat = 0;
    @(negedge tp);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge tp);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge tp);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      if (mem_en) begin
        ens++;
        wseen = mem_wdata;
      end
      @(negedge tp);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    rd  = rsp_rdata;
    flt = rsp_fault;
  endtask

  initial begin
    logic [14:0] rd, ws;
    logic        flt;
    int          ens, lat;
    int          ta [3];
    int          acc, run, maxrun, pulses;

    #1 rst_n = 1'b0;
    #1;
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);

    preload(12'h408, 15'h5A5A);
    preload(12'h3FF, 15'h1234);
    preload(12'h400, 15'h0BCD);
    preload(12'hFFF, 15'h7001);
    preload(12'h020, 15'h1111);

    @(negedge tp);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);

    xact(1'b1, 12'h004, 15'h0007, rd, flt, ens, ws, lat);
    check("wr004_latency", 32'(lat), 32'd4);
    check("wr004_en",      32'(ens), 32'd1);
    check("wr004_fault",   32'(flt), 32'd0);
    check("wr004_mem",     32'(mem[12'h004]), 32'h0007);

    xact(1'b0, 12'h004, 15'h0, rd, flt, ens, ws, lat);
    check("rd004_en",    32'(ens), 32'd1);
    check("rd004_rdata", 32'(rd),  32'h0007);
    check("rd004_fault", 32'(flt), 32'd0);
    check("rd004_wseen", 32'(ws),  32'h0007);

    xact(1'b1, 12'h408, 15'h0002, rd, flt, ens, ws, lat);
    check("wr408_en",    32'(ens), 32'd0);
    check("wr408_fault", 32'(flt), 32'd1);
    xact(1'b0, 12'h408, 15'h0, rd, flt, ens, ws, lat);
    check("rd408_rdata", 32'(rd),  32'h5A5A);
    check("rd408_fault", 32'(flt), 32'd0);
    check("rd408_mem",   32'(mem[12'h408]), 32'h5A5A);

    xact(1'b0, 12'h3FF, 15'h0, rd, flt, ens, ws, lat);
    check("rd3ff_en",    32'(ens), 32'd1);
    check("rd3ff_wseen", 32'(ws),  32'h1234);
    check("rd3ff_rdata", 32'(rd),  32'h1234);
    xact(1'b0, 12'h400, 15'h0, rd, flt, ens, ws, lat);
    check("rd400_en",    32'(ens), 32'd0);
    check("rd400_rdata", 32'(rd),  32'h0BCD);
    check("rd400_fault", 32'(flt), 32'd0);

    xact(1'b1, 12'h3FF, 15'h0055, rd, flt, ens, ws, lat);
    check("wr3ff_en",    32'(ens), 32'd1);
    check("wr3ff_fault", 32'(flt), 32'd0);
    check("wr3ff_rdata", 32'(rd),  32'h1234);
    check("wr3ff_mem",   32'(mem[12'h3FF]), 32'h0055);
    xact(1'b1, 12'hFFF, 15'h0123, rd, flt, ens, ws, lat);
    check("wrfff_en",    32'(ens), 32'd0);
    check("wrfff_fault", 32'(flt), 32'd1);
    xact(1'b0, 12'hFFF, 15'h0, rd, flt, ens, ws, lat);
    check("rdfff_rdata", 32'(rd),  32'h7001);

    repeat (3) @(negedge tp);
    check("rdata_hold", 32'(rsp_rdata), 32'h7001);

    @(negedge tp);
    req_we = 1'b0; req_addr = 12'h004; req_valid = 1'b1;
    acc = 0; run = 0; maxrun = 0; pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (acc == 3) req_valid = 1'b0;
      if (req_valid && req_ready && acc < 3) begin
        ta[acc] = cyc;
        acc++;
      end
      if (rsp_valid) begin
        pulses++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      @(negedge tp);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_gap01",   32'(ta[1] - ta[0]), 32'd4);
    check("b2b_gap12",   32'(ta[2] - ta[1]), 32'd4);
    check("b2b_pulses",  32'(pulses), 32'd3);
    check("b2b_width",   32'(maxrun), 32'd1);

    @(negedge tp);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 12'h020; req_wdata = 15'h2222;
    @(negedge tp);
    req_valid = 1'b0;
    @(negedge tp);
    @(negedge tp);
    check("mr_en_before", 32'(mem_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_mem_en",    32'(mem_en),    32'd0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_rsp_fault", 32'(rsp_fault), 32'd0);
    check("mr_mem_addr",  32'(mem_addr),  32'd0);
    check("mr_mem_wdata", 32'(mem_wdata), 32'd0);
    check("mr_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge tp);
    @(negedge tp);
    rst_n = 1'b1;
    #1;
    check("mr_ready", 32'(req_ready), 32'd1);
    check("mr_mem",   32'(mem[12'h020]), 32'h1111);

    xact(1'b1, 12'h010, 15'h0001, rd, flt, ens, ws, lat);
    check("ed010_mem", 32'(mem[12'h010]), 32'(E010));
    xact(1'b0, 12'h010, 15'h0, rd, flt, ens, ws, lat);
    check("ed010_rdata",   32'(rd), 32'(E010));
    check("ed010_restore", 32'(mem[12'h010]), 32'(E010));
    xact(1'b1, 12'h013, 15'h4080, rd, flt, ens, ws, lat);
    check("ed013_mem", 32'(mem[12'h013]), 32'(E013));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/agc_mem_sequencer.md
Name: agc_mem_sequencer

Overview:
- Initiator side of the AGC memory interface. Takes single-word read/write requests from the CPU control path and runs a full memory cycle against the erasable/fixed data memory.
- Drives the memory's enable, 12-bit address and 15-bit write data. Captures read data into a G register.
- Always writes back (restores) erasable words, as core memory requires.
- Blocks writes to fixed memory and reports them as a protection fault.

Parameters:
- AW, 12, memory address width.
- DW, 15, memory word width.
- ERASABLE_TOP, 12'h3FF, highest erasable address. Addresses above it are fixed (read-only).

Ports:
- tp  input  1  timing-pulse clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CPU request strobe.
- req_ready  output  1  sequencer can accept a request.
- req_we  input  1  1 = write req_wdata, 0 = read.
- req_addr  input  AW  target address.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DW  G register: word as read, before any write.
- rsp_fault  output  1  valid with rsp_valid; 1 = write to fixed memory refused.
- mem_en  output  1  memory write enable, sampled by memory on tp rising edge.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data (combinational from mem_addr).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - mem_en=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_fault=0, rsp_rdata=0.
  - req_ready=1 once rst_n has been released.
- Reset asserted mid-cycle aborts immediately. mem_en drops in the same instant; no partial write occurs.
- States, one tp edge each:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata; fixed = (addr > ERASABLE_TOP); go to READ.
  - READ: req_ready=0. mem_addr=latched addr; mem_en=0. Go to CAPTURE.
  - CAPTURE: G <= mem_rdata. Go to WRITE.
  - WRITE:
    - Erasable address: mem_en=1 for exactly this cycle; mem_wdata = we ? wdata : G.
    - Fixed address: mem_en stays 0. Fault latched if we=1.
    - Go to DONE.
  - DONE: rsp_valid=1 for one cycle; rsp_rdata=G; rsp_fault set as latched. Go to IDLE.
- Latency: request accepted at edge N; rsp_valid high in the cycle after edge N+3. Accept-to-accept interval is 4 cycles.
- req_valid while busy is ignored; the requester holds it until it sees req_ready.
- Reads of fixed memory return the word with no write cycle and no fault.
- Boundaries:
  - addr == ERASABLE_TOP is erasable.
  - addr == ERASABLE_TOP+1 is fixed.
  - addr 12'hFFF is fixed; no wrap-around.
- mem_addr holds its value outside active cycles. rsp_rdata holds its value until the next DONE.

Optional Feature:
- Macro AGC_EDIT_EN.
- Defined: erasable writes (we=1) to the editing addresses 12'h010–12'h013 transform req_wdata before it goes out on mem_wdata:
  - 010 CYR: rotate right 1.
  - 011 SR: shift right 1 with bit 14 preserved.
  - 012 CYL: rotate left 1.
  - 013 EDOP: shift right 7, zero fill.
  - Read-restore cycles are never edited.
- Undefined: no editing; these addresses behave as plain erasable memory.

Test Plan:
- Write/read erasable: write 15'h0007 to 12'h004, then read 12'h004. Exactly one mem_en pulse on each cycle; read response rsp_rdata=15'h0007, rsp_fault=0.
- Write to fixed: write 15'h0002 to 12'h408. mem_en never asserted, rsp_fault=1. A following read of 12'h408 returns the preloaded value, not 15'h0002.
- Restore on read: preload 12'h3FF=15'h1234 and read it. mem_wdata=15'h1234 with mem_en=1 in WRITE; rsp_rdata=15'h1234. Read 12'h400: no mem_en.
- Handshake and latency: hold req_valid high for 3 back-to-back requests. Accepts are 4 cycles apart; each rsp_valid is a single-cycle pulse.
- Mid-cycle reset: pull rst_n low during WRITE. All outputs go to 0 immediately, target word is unchanged, req_ready=1 after release.
- AGC_EDIT_EN: write 15'h0001 to 12'h010; stored value is 15'h4000 (with macro) or 15'h0001 (without).
